// File: rtl/alu_issue_arbiter_pkg.sv
// rtl/alu_issue_arbiter_pkg.sv - ALU opcode constants, request struct and legal-op check
//
// Package operationList, shared by the arbiter, FU_ALU and dispatch logic.
//   op_t        : 3-bit ALU opcode
//   addop..sraop: the five legal opcodes; every other code is illegal
//   alu_req_t   : one issue request (op, a, b, tag)
//   is_legal_op : 1 when an opcode is one of the five legal ops
package operationList;

    typedef logic [2:0] op_t;

    localparam op_t addop = 3'd0;
    localparam op_t subop = 3'd1;
    localparam op_t andop = 3'd2;
    localparam op_t xorop = 3'd3;
    localparam op_t sraop = 3'd4;

    localparam int ALU_DATA_W = 32;
    // Widest tag any issue port may carry; narrower tags are zero-extended.
    localparam int MAX_TAG_W  = 8;

    typedef struct packed {
        op_t                    op;
        logic [ALU_DATA_W-1:0]  a;
        logic [ALU_DATA_W-1:0]  b;
        logic [MAX_TAG_W-1:0]   tag;
    } alu_req_t;

    function automatic logic is_legal_op(input op_t op);
        return (op == addop) || (op == subop) || (op == andop) ||
               (op == xorop) || (op == sraop);
    endfunction

endpackage

// File: rtl/FU_ALU.sv
// rtl/FU_ALU.sv - 32-bit combinational ALU
//
// Ports:
//   op     in  3   opcode (operationList::op_t)
//   a, b   in  32  operands
//   result out 32  add/sub wrap mod 2^32; sra shifts a by b[4:0]; illegal op gives 0
module FU_ALU
    import operationList::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (op)
            addop:   result = a + b;
            subop:   result = a - b;
            andop:   result = a & b;
            xorop:   result = a ^ b;
            sraop:   result = $unsigned($signed(a) >>> b[4:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// rtl/alu_issue_arbiter_rr_arbiter.sv - combinational round-robin priority pick
//
// Ports:
//   req    in  N   request vector
//   ptr    in  IW  highest-priority index for this cycle
//   grant  out N   one-hot grant, zero when no request
//   win    out IW  index of the granted request (0 when none)
//   any    out 1   some request is set
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] win,
    output logic          any
);

    int            j;
    logic [IW-1:0] idx;

    // Walk ptr, ptr+1, ... wrapping at N; the first set bit wins.
    always_comb begin
        grant = '0;
        win   = '0;
        any   = 1'b0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            idx = IW'(j);
            if (!any && req[idx]) begin
                any        = 1'b1;
                win        = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// rtl/alu_issue_arbiter.sv - round-robin sharing of one FU_ALU between issue ports
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot or zero
//   req_op/a/b/tag       flattened per-requester opcode, operands, destination tag
//   res_valid/res_ready  one-entry result register handshake
//   res_data/tag/src     result, its tag and the index of the producing requester
//   res_err              (only with ALU_ARB_ILLEGAL_OP_FLAG_EN) result came from an illegal opcode
module alu_issue_arbiter
    import operationList::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*3-1:0]  req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic [TAG_W-1:0]      res_tag,
    output logic [SRC_W-1:0]      res_src
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
    ,
    output logic                  res_err
`endif
);

    alu_req_t              reqs [NUM_REQ];
    alu_req_t              sel;
    logic [NUM_REQ-1:0]    grant;
    logic [SRC_W-1:0]      win;
    logic                  any_req;
    logic                  can_accept;
    logic                  transfer;
    logic [DATA_W-1:0]     alu_result;
    logic                  unused_sel_tag;

    logic                  res_valid_q, res_valid_d;
    logic [DATA_W-1:0]     res_data_q,  res_data_d;
    logic [TAG_W-1:0]      res_tag_q,   res_tag_d;
    logic [SRC_W-1:0]      res_src_q,   res_src_d;
    logic [SRC_W-1:0]      rr_ptr_q,    rr_ptr_d;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
    logic                  res_err_q,   res_err_d;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].op  = req_op[i*3 +: 3];
            reqs[i].a   = req_a[i*DATA_W +: DATA_W];
            reqs[i].b   = req_b[i*DATA_W +: DATA_W];
            reqs[i].tag = MAX_TAG_W'(req_tag[i*TAG_W +: TAG_W]);
        end
    end

    rr_arbiter #(.N(NUM_REQ), .IW(SRC_W)) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .win   (win),
        .any   (any_req)
    );

    assign sel            = reqs[win];
    // Upper tag bits are zero padding from the shared struct.
    assign unused_sel_tag = ^sel.tag;

    FU_ALU u_fu_alu (
        .op     (sel.op),
        .a      (sel.a),
        .b      (sel.b),
        .result (alu_result)
    );

    // The output slot is free if empty or being drained this cycle.
    assign can_accept = !res_valid_q || res_ready;
    assign transfer   = any_req && can_accept && !rst;
    assign req_ready  = transfer ? grant : '0;

    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_tag_d   = res_tag_q;
        res_src_d   = res_src_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
        res_err_d   = res_err_q;
`endif
        if (transfer) begin
            res_valid_d = 1'b1;
            res_data_d  = alu_result;
            res_tag_d   = sel.tag[TAG_W-1:0];
            res_src_d   = win;
            rr_ptr_d    = (win == SRC_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
            res_err_d   = !is_legal_op(sel.op);
`endif
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
            res_src_q   <= '0;
            rr_ptr_q    <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
            res_err_q   <= 1'b0;
`endif
        end else begin
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_tag_q   <= res_tag_d;
            res_src_q   <= res_src_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
            res_err_q   <= res_err_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign res_src   = res_src_q;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
    assign res_err   = res_err_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb/tb_alu_issue_arbiter.sv - self-checking bench for alu_issue_arbiter
module tb_alu_issue_arbiter;
    import operationList::*;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*3-1:0]   req_op;
    logic [N*32-1:0]  req_a;
    logic [N*32-1:0]  req_b;
    logic [N*4-1:0]   req_tag;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [3:0]       res_tag;
    logic [1:0]       res_src;
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
    logic             res_err;
`endif

    logic [2:0]  t_op  [N];
    logic [31:0] t_a   [N];
    logic [31:0] t_b   [N];
    logic [3:0]  t_tag [N];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_data;
    logic [3:0]  m_tag;
    int          m_src;
    bit          m_err;
    int          m_ptr;
    int          last_xfer;

    alu_issue_arbiter #(.NUM_REQ(N), .DATA_W(32), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_tag   (req_tag),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_src   (res_src)
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
        ,
        .res_err   (res_err)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_op[i*3 +: 3]   = t_op[i];
            req_a[i*32 +: 32]  = t_a[i];
            req_b[i*32 +: 32]  = t_b[i];
            req_tag[i*4 +: 4]  = t_tag[i];
        end
    end

    function automatic int model_win(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [31:0] model_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int sh;
        sh = int'(b % 32);
        case (int'(op))
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a ^ b;
            4: r = a[31] ? ~((~a) >> sh) : (a >> sh);
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        if (rst) return '0;
        if (m_valid && !res_ready) return '0;
        w = model_win(req_valid, m_ptr);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    // One clock edge: advance the model with the inputs present before the edge.
    task automatic tick();
        int w;
        bit can;
        @(posedge clk);
        last_xfer = -1;
        if (rst) begin
            m_valid = 0; m_data = 0; m_tag = 0; m_src = 0; m_err = 0; m_ptr = 0;
        end else begin
            w   = model_win(req_valid, m_ptr);
            can = !m_valid || res_ready;
            if (can && w >= 0) begin
                m_valid   = 1;
                m_data    = model_alu(t_op[w], t_a[w], t_b[w]);
                m_tag     = t_tag[w];
                m_src     = w;
                m_err     = !(int'(t_op[w]) < 5);
                m_ptr     = (w + 1) % N;
                last_xfer = w;
            end else if (m_valid && res_ready) begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; res_ready = 0; req_valid = '1;
        for (int i = 0; i < N; i++) begin
            t_op[i] = addop; t_a[i] = $urandom; t_b[i] = $urandom; t_tag[i] = 4'(i);
        end
        #1;
        checks++;
        if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        tick(); tick();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        checks++;
        if (res_data !== 32'h0 || res_tag !== 4'h0 || res_src !== 2'd0)
            begin errors++; $display("FAIL reset_res_fields got %h/%h/%0d exp 0/0/0", res_data, res_tag, res_src); end
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
        checks++;
        if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err got %b exp 0", res_err); end
`endif
        rst = 0; req_valid = '0;
        tick();
    endtask

    task automatic test_single_add();
        t_op[0] = addop; t_a[0] = 5; t_b[0] = 3; t_tag[0] = 2;
        req_valid = 4'b0001; res_ready = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL add_req_ready got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'd8 || res_tag !== 4'd2 || res_src !== 2'd0)
            begin errors++; $display("FAIL add_result got v%b %h t%h s%0d exp v1 8 t2 s0", res_valid, res_data, res_tag, res_src); end
        tick();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", res_valid); end
    endtask

    task automatic test_arith_edges();
        t_op[1] = sraop; t_a[1] = 32'h8000_0000; t_b[1] = 32'h24;
        req_valid = 4'b0010; res_ready = 1;
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'hF800_0000)
            begin errors++; $display("FAIL sra_edge got v%b %h exp v1 f8000000", res_valid, res_data); end
        t_op[2] = subop; t_a[2] = 0; t_b[2] = 1;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFFF || res_src !== 2'd2)
            begin errors++; $display("FAIL sub_wrap got v%b %h s%0d exp v1 ffffffff s2", res_valid, res_data, res_src); end
        tick();
    endtask

    task automatic test_round_robin();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < N; i++) begin
            t_op[i] = 3'($urandom_range(0, 4)); t_a[i] = $urandom; t_b[i] = $urandom; t_tag[i] = 4'($urandom);
        end
        req_valid = '1; res_ready = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || int'(res_src) != (k % N) || res_data !== m_data)
                begin errors++; $display("FAIL rr_step%0d got v%b s%0d %h exp v1 s%0d %h", k, res_valid, res_src, res_data, k % N, m_data); end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] sd;
        logic [3:0]  st;
        t_op[2] = xorop; t_a[2] = $urandom; t_b[2] = $urandom; t_tag[2] = 4'hA;
        req_valid = 4'b0100; res_ready = 0;
        tick();
        sd = model_alu(xorop, t_a[2], t_b[2]); st = 4'hA;
        t_op[1] = andop; t_a[1] = $urandom; t_b[1] = $urandom; t_tag[1] = 4'h5;
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req_ready !== '0) begin errors++; $display("FAIL bp_ready%0d got %b exp 0", k, req_ready); end
            tick();
            checks++;
            if (res_valid !== 1'b1 || res_data !== sd || res_tag !== st || res_src !== 2'd2)
                begin errors++; $display("FAIL bp_hold%0d got v%b %h t%h s%0d exp v1 %h t%h s2", k, res_valid, res_data, res_tag, res_src, sd, st); end
        end
        res_ready = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", req_ready); end
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_src !== 2'd1 || res_tag !== 4'h5 || res_data !== (t_a[1] & t_b[1]))
            begin errors++; $display("FAIL bp_refill got v%b s%0d t%h %h exp v1 s1 t5 %h", res_valid, res_src, res_tag, res_data, t_a[1] & t_b[1]); end
        tick();
    endtask

    task automatic test_illegal();
        t_op[0] = 3'b111; t_a[0] = 7; t_b[0] = 9; t_tag[0] = 4'h3;
        req_valid = 4'b0001; res_ready = 1;
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_data !== 32'h0 || res_src !== 2'd0)
            begin errors++; $display("FAIL illegal_op got v%b %h s%0d exp v1 0 s0", res_valid, res_data, res_src); end
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
        checks++;
        if (res_err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b exp 1", res_err); end
`endif
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1; tick(); rst = 0;
        t_op[1] = addop; t_a[1] = 1; t_b[1] = 1; t_tag[1] = 1;
        req_valid = 4'b0010; res_ready = 0;
        tick();
        req_valid = '0;
        checks++;
        if (res_valid !== 1'b1 || res_src !== 2'd1)
            begin errors++; $display("FAIL rstmid_setup got v%b s%0d exp v1 s1", res_valid, res_src); end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", res_valid); end
        req_valid = '1; res_ready = 1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_grant got %b exp 0001", req_ready); end
        tick();
        req_valid = '0;
        checks++;
        if (res_src !== 2'd0) begin errors++; $display("FAIL rstmid_src got %0d exp 0", res_src); end
        tick();
    endtask

    task automatic test_random();
        int wait_cnt [N];
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        req_valid = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    req_valid[i] = 1'b1;
                    t_op[i]  = ($urandom % 8 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                    t_a[i]   = $urandom; t_b[i] = $urandom; t_tag[i] = 4'($urandom);
                end
            end
            res_ready = ($urandom % 4 != 0);
            #1;
            checks++;
            if (req_ready !== model_ready())
                begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", cyc, req_ready, model_ready()); end
            tick();
            checks++;
            if (res_valid !== m_valid)
                begin errors++; $display("FAIL rnd_valid c%0d got %b exp %b", cyc, res_valid, m_valid); end
            if (m_valid) begin
                checks++;
                if (res_data !== m_data || res_tag !== m_tag || int'(res_src) != m_src)
                    begin errors++; $display("FAIL rnd_result c%0d got %h t%h s%0d exp %h t%h s%0d", cyc, res_data, res_tag, res_src, m_data, m_tag, m_src); end
`ifdef ALU_ARB_ILLEGAL_OP_FLAG_EN
                checks++;
                if (res_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, res_err, m_err); end
`endif
            end
            if (last_xfer >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (i == last_xfer) wait_cnt[i] = 0;
                    else if (req_valid[i]) begin
                        wait_cnt[i]++;
                        checks++;
                        if (wait_cnt[i] > N - 1)
                            begin errors++; $display("FAIL rnd_fair req%0d waited %0d transfers exp <= %0d", i, wait_cnt[i], N - 1); end
                    end
                end
                req_valid[last_xfer] = 1'b0;
            end
        end
        req_valid = '0; res_ready = 1;
        tick();
    endtask

    initial begin
        rst = 1; req_valid = '0; res_ready = 0;
        m_valid = 0; m_data = 0; m_tag = 0; m_src = 0; m_err = 0; m_ptr = 0; last_xfer = -1;
        test_reset();
        test_single_add();
        test_arith_edges();
        test_round_robin();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
